multimode_reg: RTL

Parametrised WIDTH-bit register that generalises the team's single-bit D and T flops into one multi-mode storage element. It supports load, toggle, set/clear, shift and up/down count operations, and reports carry/borrow and a sticky overflow flag. It is the common building block for control registers, shift chains and small counters in the datapath.

---
 rtl/mmr_pkg.sv | 19 +
 rtl/multimode_reg.sv | 92 +++++++++
 2 files changed

// File: rtl/mmr_pkg.sv
// Shared definitions for the multi-mode register: mode encodings and mode type.
// No logic; pure declarations.
// Imported by any block that drives the register's mode input.
package mmr_pkg;

  typedef enum logic [2:0] {
    MMR_HOLD   = 3'd0,
    MMR_LOAD   = 3'd1,
    MMR_TOGGLE = 3'd2,
    MMR_SETCLR = 3'd3,
    MMR_SHL    = 3'd4,
    MMR_SHR    = 3'd5,
    MMR_UP     = 3'd6,
    MMR_DOWN   = 3'd7
  } mmr_mode_e;

  localparam int unsigned MMR_MODE_W = 3;

endpackage : mmr_pkg

// File: rtl/multimode_reg.sv
// WIDTH-bit register with load/toggle/set-clear/shift/up-down count, carry pulse and sticky overflow.
// Latency: 1 cycle from input sample to q/carry/ovf; zero is combinational from q.
// No backpressure: accepts a new operation every cycle, en=0 holds.
module multimode_reg
  import mmr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [MMR_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]      d,
  input  logic [WIDTH-1:0]      t,
  input  logic                  ser_in,
  input  logic                  clr_ovf,
  output logic [WIDTH-1:0]      q,
  output logic                  carry,
  output logic                  ovf,
  output logic                  zero
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  mmr_mode_e        mode_e;

  assign mode_e = mmr_mode_e'(mode);

  // Next q and carry from the selected operation; carry is always derived from the pre-update q.
  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    if (en) begin
      unique case (mode_e)
        MMR_HOLD:   q_d = q_q;
        MMR_LOAD:   q_d = d;
        MMR_TOGGLE: q_d = q_q ^ t;
        // Clear mask applied after the set mask so a bit both set and cleared ends up 0.
        MMR_SETCLR: q_d = (q_q | d) & ~t;
        MMR_SHL: begin
          q_d     = {q_q[WIDTH-2:0], ser_in};
          carry_d = q_q[WIDTH-1];
        end
        MMR_SHR: begin
          q_d     = {ser_in, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        // Wrap/borrow detected from old q directly, avoiding a WIDTH+1 adder.
        MMR_UP: begin
          q_d     = q_q + WIDTH'(1);
          carry_d = &q_q;
        end
        MMR_DOWN: begin
          q_d     = q_q - WIDTH'(1);
          carry_d = ~|q_q;
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Sticky overflow: a carry in this cycle takes priority over a clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (carry_d) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State update; reset overrides everything and drops any in-progress sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= RST_VAL;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zero  = (q_q == '0);

endmodule : multimode_reg
